// File: rtl/tone_sequencer.sv
// Score-driven square-wave buzzer: a small score RAM is stepped through by a
// FETCH/PLAY/GAP sequencer, each entry selecting a pitch, octave and length in ticks.
module tone_sequencer #(
  parameter int CLK_HZ    = 50000000,
  parameter int TICK_HZ   = 50,
  parameter int DEPTH     = 32,
  parameter int GAP_TICKS = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [11:0]   wr_data,
  input  logic          start,
  input  logic          stop,
  input  logic          loop_en,
  output logic          busy,
  output logic          note_strobe,
  output logic [AW-1:0] cur_addr,
  output logic          tone_out
);

  localparam int     TDIV = CLK_HZ / TICK_HZ;
  localparam longint HPK  = longint'(CLK_HZ) * 50;

  // Half-period in clocks for the octave-0 pitch of each note (F given x100).
  function automatic logic [31:0] hp_base(input logic [3:0] n);
    case (n)
      4'd0:    hp_base = 32'(HPK / 26163);
      4'd1:    hp_base = 32'(HPK / 27718);
      4'd2:    hp_base = 32'(HPK / 29366);
      4'd3:    hp_base = 32'(HPK / 31113);
      4'd4:    hp_base = 32'(HPK / 32963);
      4'd5:    hp_base = 32'(HPK / 34923);
      4'd6:    hp_base = 32'(HPK / 36999);
      4'd7:    hp_base = 32'(HPK / 39200);
      4'd8:    hp_base = 32'(HPK / 41530);
      4'd9:    hp_base = 32'(HPK / 44000);
      4'd10:   hp_base = 32'(HPK / 46616);
      default: hp_base = 32'(HPK / 49388);
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, FETCH, PLAY, GAP} state_t;

  state_t        state, state_nxt, adv_state;
  logic [11:0]   mem [DEPTH];
  logic [11:0]   rd_data;
  logic [AW-1:0] fa, fa_nxt;
  logic [31:0]   tick_cnt, tl, tl_nxt, div, div_nxt, hp_r;
  logic          tick, accept, latch, rest_r, tone_nxt, last;

  assign tick      = tick_cnt == 32'(TDIV - 1);
  assign last      = fa == AW'(DEPTH - 1);
  assign adv_state = (last && !loop_en) ? IDLE : FETCH;
  assign busy      = state != IDLE;

  // Read address is the one the FSM is about to fetch, so data is ready in FETCH.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[fa_nxt];
  end

  always_comb begin
    state_nxt = state;
    fa_nxt    = fa;
    tl_nxt    = tl;
    accept    = 1'b0;
    latch     = 1'b0;
    if (stop) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (start) begin
          state_nxt = FETCH;
          fa_nxt    = '0;
          accept    = 1'b1;
        end
        FETCH: begin
          if (rd_data[11:6] == 6'd0) begin
            if (fa == '0 || !loop_en) state_nxt = IDLE;
            else fa_nxt = '0;
          end else begin
            latch     = 1'b1;
            state_nxt = PLAY;
            tl_nxt    = 32'(rd_data[11:6]);
          end
        end
        PLAY: if (tick) begin
          if (tl == 32'd1) begin
            if (GAP_TICKS > 0) begin
              state_nxt = GAP;
              tl_nxt    = 32'(GAP_TICKS);
            end else begin
              state_nxt = adv_state;
              fa_nxt    = fa + AW'(1);
            end
          end else begin
            tl_nxt = tl - 32'd1;
          end
        end
        GAP: if (tick) begin
          if (tl == 32'd1) begin
            state_nxt = adv_state;
            fa_nxt    = fa + AW'(1);
          end else begin
            tl_nxt = tl - 32'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // The tone only runs while staying in PLAY; any exit silences it on the same edge.
  always_comb begin
    div_nxt  = '0;
    tone_nxt = 1'b0;
    if (state == PLAY && state_nxt == PLAY) begin
      if (div == hp_r - 32'd1) begin
        div_nxt  = '0;
        tone_nxt = tone_out ^ !rest_r;
      end else begin
        div_nxt  = div + 32'd1;
        tone_nxt = tone_out;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state       <= IDLE;
      fa          <= '0;
      tl          <= '0;
      div         <= '0;
      tick_cnt    <= '0;
      tone_out    <= 1'b0;
      note_strobe <= 1'b0;
      cur_addr    <= '0;
      hp_r        <= '0;
      rest_r      <= 1'b0;
    end else begin
      state       <= state_nxt;
      fa          <= fa_nxt;
      tl          <= tl_nxt;
      div         <= div_nxt;
      tone_out    <= tone_nxt;
      tick_cnt    <= (accept || tick) ? '0 : tick_cnt + 32'd1;
      note_strobe <= latch;
      if (latch) begin
        cur_addr <= fa;
        hp_r     <= hp_base(rd_data[3:0]) >> rd_data[5:4];
        rest_r   <= rd_data[3:0] >= 4'd12;
      end
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: scores are played and the strobe/tone/busy timeline is
// compared with one derived from note frequencies and tick arithmetic.
module tb_tone_sequencer;
  localparam int DEPTH = 4;
  localparam int GAP   = 1;
  localparam int TDIV  = 1000;
  localparam int F100 [12] = '{26163, 27718, 29366, 31113, 32963, 34923,
                               36999, 39200, 41530, 44000, 46616, 49388};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1, wr_en = 1'b0, start = 1'b0, stop = 1'b0, loop_en = 1'b0;
  logic [1:0]  wr_addr = '0;
  logic [11:0] wr_data = '0;
  logic        busy, note_strobe, tone_out;
  logic [1:0]  cur_addr;

  always #5 clk = ~clk;

  tone_sequencer #(.CLK_HZ(1000000), .TICK_HZ(1000), .DEPTH(DEPTH), .GAP_TICKS(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .stop(stop), .loop_en(loop_en), .busy(busy),
    .note_strobe(note_strobe), .cur_addr(cur_addr), .tone_out(tone_out));

  int vectors = 0, miscompares = 0;
  int exp_addr[$], exp_time[$], exp_rise[$], exp_busy, exp_limit;
  int cap_addr[$], cap_time[$], cap_rise[$], cap_busy;

  typedef struct {
    logic [3:0][11:0] sc;
    bit               lp;
    int               pulse_at;
    int               wa_at;
    logic [1:0]       wa;
    logic [11:0]      wd;
  } scen_t;

  function automatic logic [11:0] ent(input int n, input int o, input int d);
    return {6'(d), 2'(o), 4'(n)};
  endfunction

  function automatic logic [3:0][11:0] mks(input logic [11:0] e0, e1, e2, e3);
    logic [3:0][11:0] r;
    r[0] = e0; r[1] = e1; r[2] = e2; r[3] = e3;
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Timeline of a run: every entry costs 1000*(dur+GAP) clocks starting with its fetch.
  task automatic model(input logic [3:0][11:0] sc, input bit lp);
    int t = 0, a = 0, notes = 0, d, n, hp, len;
    exp_addr.delete(); exp_time.delete(); exp_rise.delete();
    exp_busy = -1; exp_limit = 0;
    for (int step = 0; step < 64; step++) begin
      d = int'(sc[a][11:6]);
      if (d == 0) begin
        if (a == 0 || !lp) begin exp_busy = t + 1; return; end
        a = 0; t++;
        continue;
      end
      exp_addr.push_back(a); exp_time.push_back(t + 1);
      if (notes == 4) begin exp_limit = t + 1; return; end
      n = int'(sc[a][3:0]);
      if (n < 12) begin
        hp  = (50000000 / F100[n]) >> sc[a][5:4];
        len = TDIV * d - 1;
        for (int k = 1; k * hp <= len - 1; k += 2) exp_rise.push_back(t + 1 + k * hp);
      end
      notes++;
      t += TDIV * (d + GAP);
      if (a == DEPTH - 1) begin
        if (!lp) begin exp_busy = t; return; end
        a = 0;
      end else a++;
    end
  endtask

  task automatic write_score(input logic [3:0][11:0] sc);
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1; wr_addr = 2'(i); wr_data = sc[i];
      cyc();
    end
    wr_en = 1'b0;
  endtask

  task automatic capture(input int limit, input int pulse_at, input int wa_at,
                         input logic [1:0] wa, input logic [11:0] wd);
    logic prev = 1'b0;
    cap_addr.delete(); cap_time.delete(); cap_rise.delete(); cap_busy = 0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int t = 0; t <= limit; t++) begin
      if (!busy) break;
      cap_busy++;
      if (note_strobe) begin cap_addr.push_back(int'(cur_addr)); cap_time.push_back(t); end
      if (tone_out && !prev) cap_rise.push_back(t);
      prev    = tone_out;
      start   = (t == pulse_at);
      wr_en   = (t == wa_at);
      wr_addr = wa;
      wr_data = wd;
      cyc();
    end
    start = 1'b0; wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    repeat (3) cyc();
    vectors++;
    if ({busy, note_strobe, cur_addr, tone_out} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_state got %b want 00000", {busy, note_strobe, cur_addr, tone_out});
    end
    rst_n = 1'b0;
    cyc();
  endtask

  task automatic test_start_stop_idle();
    start = 1'b1; stop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      vectors++;
      if (busy !== 1'b0) begin
        miscompares++;
        $display("FAIL start_stop_idle cycle %0d busy got %b want 0", i, busy);
      end
    end
    start = 1'b0; stop = 1'b0;
    cyc();
  endtask

  // Play a long A, wait for the tone to go high, then abort with stop or reset.
  task automatic test_abort(input bit use_reset);
    int waited = 0;
    write_score(mks(ent(9, 0, 3), 12'h0, 12'h0, 12'h0));
    start = 1'b1; cyc(); start = 1'b0;
    while (tone_out !== 1'b1 && waited < 3000) begin cyc(); waited++; end
    vectors++;
    if (tone_out !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_tone_high got %b want 1 after %0d cycles", tone_out, waited);
    end
    if (use_reset) rst_n = 1'b1; else stop = 1'b1;
    cyc();
    vectors++;
    if ({busy, tone_out, note_strobe, use_reset ? cur_addr : 2'b00} !== 5'b0) begin
      miscompares++;
      $display("FAIL abort_%s got busy=%b tone=%b strobe=%b addr=%0d want all 0",
               use_reset ? "reset" : "stop", busy, tone_out, note_strobe, cur_addr);
    end
    rst_n = 1'b0; stop = 1'b0;
    cyc();
  endtask

  task automatic test_scores();
    scen_t            tbl[$];
    scen_t            s;
    logic [3:0][11:0] eff;
    int               nmin;
    s = '{sc: mks(ent(9, 0, 2), 12'h0, 12'h0, 12'h0), lp: 1'b0, pulse_at: 500,
          wa_at: -1, wa: 2'd0, wd: 12'h0};
    tbl.push_back(s);
    s.pulse_at = -1;
    s.sc = mks(ent(0, 1, 1), 12'h0, 12'h0, 12'h0);                      tbl.push_back(s);
    s.sc = mks(ent(15, 0, 3), 12'h0, 12'h0, 12'h0);                     tbl.push_back(s);
    s.sc = mks(ent(0, 0, 1), ent(4, 0, 1), ent(7, 2, 1), ent(11, 3, 1)); s.lp = 1'b1;
    tbl.push_back(s);
    s.lp = 1'b0;                                                        tbl.push_back(s);
    s.sc = mks(12'h0, ent(9, 0, 1), 12'h0, 12'h0); s.lp = 1'b1;          tbl.push_back(s);
    s.sc = mks(ent(9, 0, 1), ent(11, 0, 1), ent(13, 1, 1), 12'h0); s.lp = 1'b0;
    s.wa_at = 100; s.wa = 2'd1; s.wd = ent(0, 1, 1);                    tbl.push_back(s);
    s.wa_at = -1;
    for (int r = 0; r < 3; r++) begin
      s.sc[0] = ent($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(1, 2));
      for (int i = 1; i < DEPTH; i++)
        s.sc[i] = ent($urandom_range(0, 15), $urandom_range(0, 3),
                      ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 2));
      s.lp = 1'($urandom_range(0, 1));
      tbl.push_back(s);
    end

    foreach (tbl[k]) begin
      write_score(tbl[k].sc);
      loop_en = tbl[k].lp;
      eff = tbl[k].sc;
      if (tbl[k].wa_at >= 0) eff[tbl[k].wa] = tbl[k].wd;
      model(eff, tbl[k].lp);
      capture(exp_busy >= 0 ? exp_busy + 5 : exp_limit, tbl[k].pulse_at,
              tbl[k].wa_at, tbl[k].wa, tbl[k].wd);

      vectors++;
      if (cap_addr.size() !== exp_addr.size()) begin
        miscompares++;
        $display("FAIL scen%0d strobe_count got %0d want %0d", k, cap_addr.size(), exp_addr.size());
      end
      nmin = (cap_addr.size() < exp_addr.size()) ? cap_addr.size() : exp_addr.size();
      for (int i = 0; i < nmin; i++) begin
        vectors++;
        if (cap_addr[i] !== exp_addr[i] || cap_time[i] !== exp_time[i]) begin
          miscompares++;
          $display("FAIL scen%0d strobe%0d got addr=%0d t=%0d want addr=%0d t=%0d",
                   k, i, cap_addr[i], cap_time[i], exp_addr[i], exp_time[i]);
        end
      end
      vectors++;
      if (cap_rise.size() !== exp_rise.size()) begin
        miscompares++;
        $display("FAIL scen%0d tone_rise_count got %0d want %0d", k, cap_rise.size(), exp_rise.size());
      end
      nmin = (cap_rise.size() < exp_rise.size()) ? cap_rise.size() : exp_rise.size();
      for (int i = 0; i < nmin; i++) begin
        vectors++;
        if (cap_rise[i] !== exp_rise[i]) begin
          miscompares++;
          $display("FAIL scen%0d tone_rise%0d got t=%0d want t=%0d", k, i, cap_rise[i], exp_rise[i]);
        end
      end
      if (exp_busy >= 0) begin
        vectors++;
        if (cap_busy !== exp_busy) begin
          miscompares++;
          $display("FAIL scen%0d busy_cycles got %0d want %0d", k, cap_busy, exp_busy);
        end
      end else begin
        stop = 1'b1; cyc(); stop = 1'b0;
        vectors++;
        if ({busy, tone_out} !== 2'b00) begin
          miscompares++;
          $display("FAIL scen%0d stop_after_loop got busy=%b tone=%b want 0 0", k, busy, tone_out);
        end
      end
      if (busy) begin stop = 1'b1; cyc(); stop = 1'b0; end
      loop_en = 1'b0;
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_start_stop_idle();
    test_scores();
    test_abort(1'b0);
    test_abort(1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
TONE_SEQUENCER -- requirements
Module: tone_sequencer

Interface
REQ-001 Parameters SHALL be: CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 TICK_HZ, default 50, duration-tick rate in Hz.
REQ-003 DEPTH, default 32, number of score entries (power of two, at least 2); AW = clog2(DEPTH).
REQ-004 GAP_TICKS, default 1, silent articulation ticks between notes (0 allowed).
REQ-005 clk  in  1  single system clock; all logic on the rising edge.
REQ-006 rst_n  in  1  synchronous, active-high reset.
REQ-007 wr_en  in  1  score write strobe.
REQ-008 wr_addr  in  AW  score write address.
REQ-009 wr_data  in  12  score entry: [3:0] note (0..11 = C..B, 15 = rest, 12..14 = rest), [5:4] octave shift, [11:6] duration in ticks (0 = end marker).
REQ-010 start  in  1  play request, level-sampled each cycle.
REQ-011 stop  in  1  abort request.
REQ-012 loop_en  in  1  restart from entry 0 at end of score.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 note_strobe  out  1  one-cycle pulse when a new entry is latched.
REQ-015 cur_addr  out  AW  index of the entry being played.
REQ-016 tone_out  out  1  square-wave buzzer drive.

Function
REQ-017 The score SHALL be a DEPTH x 12 RAM with a synchronous write and a registered read (1-cycle latency); same-address write/read SHALL return old data.
REQ-018 The base half-period table SHALL be HP[n] = floor(CLK_HZ*50/F[n]) with F x100 = 26163, 27718, 29366, 31113, 32963, 34923, 36999, 39200, 41530, 44000, 46616, 49388; the effective half-period SHALL be HP[n] >> octave.
REQ-019 The tick counter SHALL count 0..CLK_HZ/TICK_HZ-1, pulse tick for one cycle at terminal count, and clear to 0 when start is accepted.
REQ-020 The FSM states SHALL be IDLE, FETCH, PLAY, GAP.
REQ-021 IDLE: start=1 and stop=0 -> FETCH with read address 0; tone_out=0.
REQ-022 FETCH (one cycle): a duration of 0 at address 0 -> IDLE; a duration of 0 elsewhere -> address 0 and FETCH if loop_en=1, otherwise IDLE; a nonzero duration -> latch note/octave/duration, set cur_addr, pulse note_strobe, go to PLAY.
REQ-023 PLAY: the divider SHALL start at 0 with tone_out=0 and toggle tone_out when the divider reaches the half-period minus 1; for a rest, tone_out SHALL stay 0.
REQ-024 PLAY: each tick SHALL decrement the duration; on reaching 0 -> GAP if GAP_TICKS>0, else FETCH of the next address.
REQ-025 GAP: tone_out=0 for GAP_TICKS ticks, then FETCH of the next address.
REQ-026 Next address after DEPTH-1: if loop_en=1, wrap to 0 and FETCH; otherwise IDLE.
REQ-027 stop=1 in any state -> IDLE on the next edge with tone_out=0; stop has priority over a simultaneous start.
REQ-028 start while busy SHALL be ignored; writes SHALL be accepted in every state and take effect at the next fetch of that entry.
REQ-029 loop_en SHALL be sampled only at the end-of-score decision.

Reset
REQ-030 While rst_n=1 the block SHALL go to IDLE with busy=0, note_strobe=0, cur_addr=0, tone_out=0, and the tick and divider counters at 0; RAM contents are not cleared.
REQ-031 Reset mid-play SHALL silence tone_out on the next edge.

Verification (CLK_HZ=1000000, TICK_HZ=1000, DEPTH=4, GAP_TICKS=1)
REQ-032 Score {A oct0 dur2, end}, start pulse -> note_strobe once, tone_out toggles every 1136 clocks for 2000 clocks, then 1000 silent clocks, then busy=0.
REQ-033 Entry C oct1 dur1 -> toggles every 955 clocks (1911>>1).
REQ-034 Rest entry (note 15, dur3) -> tone_out=0 for 3000 clocks while busy=1.
REQ-035 Four nonzero entries with loop_en=1 -> cur_addr sequence 0,1,2,3,0; with loop_en=0 -> IDLE after entry 3.
REQ-036 start and stop both high in IDLE -> stays IDLE; stop mid-PLAY -> busy=0 and tone_out=0 one cycle later.
REQ-037 Entry 0 = end marker with loop_en=1 -> returns to IDLE after one FETCH with no note_strobe.
